// File: rtl/peripheral_bus_arbiter.sv
// ---------------------------------------------------------------------------
// peripheral_bus_arbiter
//
// Two-master arbiter and transaction sequencer for the 24-bit peripheral bus.
// One transaction is in flight at a time. Masters are granted round-robin on
// contention. The block waits on the slave busy signal and returns all-ones
// read data when no device claims a read. A slave that stays busy too long
// is aborted with a one-cycle busTimeout pulse.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   masterN_we/oe             : write / read request from master N
//   masterN_address/...       : request fields (address, byteSelect, dataWrite)
//   masterN_dataRead          : registered read data returned to master N
//   masterN_busy              : master N must hold its request while high
//   peripheralBus_*  (out)    : slave-side request, driven from the latches
//   peripheralBus_dataRead/busy/requestOutput (in) : slave response
//   busTimeout                : one-cycle pulse in the DONE cycle of an abort
// ---------------------------------------------------------------------------
module peripheral_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        master0_we,
    input  logic        master0_oe,
    input  logic [23:0] master0_address,
    input  logic [3:0]  master0_byteSelect,
    input  logic [31:0] master0_dataWrite,
    output logic [31:0] master0_dataRead,
    output logic        master0_busy,
    input  logic        master1_we,
    input  logic        master1_oe,
    input  logic [23:0] master1_address,
    input  logic [3:0]  master1_byteSelect,
    input  logic [31:0] master1_dataWrite,
    output logic [31:0] master1_dataRead,
    output logic        master1_busy,
    output logic        peripheralBus_we,
    output logic        peripheralBus_oe,
    output logic [23:0] peripheralBus_address,
    output logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataWrite,
    input  logic [31:0] peripheralBus_dataRead,
    input  logic        peripheralBus_busy,
    input  logic        peripheralBus_requestOutput,
    output logic        busTimeout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    // Last ACCESS cycle allowed with the slave still busy.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic        oe_q, oe_d;
    logic [23:0] addr_q, addr_d;
    logic [3:0]  bsel_q, bsel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  tcount_q, tcount_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;
    logic        timeout_q, timeout_d;

    logic        req0, req1;
    logic [31:0] rd_val;

    assign req0 = master0_we | master0_oe;
    assign req1 = master1_we | master1_oe;

    // Undriven bus reads back as all-ones, like an open-drain bus.
    assign rd_val = peripheralBus_requestOutput ? peripheralBus_dataRead : 32'hFFFF_FFFF;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        oe_d         = oe_q;
        addr_d       = addr_q;
        bsel_d       = bsel_q;
        wdata_d      = wdata_q;
        tcount_d     = tcount_q;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    // On contention favour whoever was not served last.
                    grant_d = (req0 & req1) ? ~last_grant_q : req1;
                    if (grant_d) begin
                        we_d    = master1_we;
                        oe_d    = master1_oe;
                        addr_d  = master1_address;
                        bsel_d  = master1_byteSelect;
                        wdata_d = master1_dataWrite;
                    end else begin
                        we_d    = master0_we;
                        oe_d    = master0_oe;
                        addr_d  = master0_address;
                        bsel_d  = master0_byteSelect;
                        wdata_d = master0_dataWrite;
                    end
                    tcount_d = 8'd0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (!peripheralBus_busy) begin
                    if (oe_q) begin
                        if (grant_q) rd1_d = rd_val;
                        else         rd0_d = rd_val;
                    end
                    state_d = DONE;
                end else if (tcount_q == TMO_LAST) begin
                    // Abort: the master sees all-ones even for a write.
                    if (grant_q) rd1_d = 32'hFFFF_FFFF;
                    else         rd0_d = 32'hFFFF_FFFF;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tcount_d = tcount_q + 8'd1;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
            addr_q       <= 24'd0;
            bsel_q       <= 4'd0;
            wdata_q      <= 32'd0;
            tcount_q     <= 8'd0;
            rd0_q        <= 32'hFFFF_FFFF;
            rd1_q        <= 32'hFFFF_FFFF;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            oe_q         <= oe_d;
            addr_q       <= addr_d;
            bsel_q       <= bsel_d;
            wdata_q      <= wdata_d;
            tcount_q     <= tcount_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            timeout_q    <= timeout_d;
        end
    end

    // Strobes only while the access is on the bus; fields stay latched.
    assign peripheralBus_we         = (state_q == ACCESS) & we_q;
    assign peripheralBus_oe         = (state_q == ACCESS) & oe_q;
    assign peripheralBus_address    = addr_q;
    assign peripheralBus_byteSelect = bsel_q;
    assign peripheralBus_dataWrite  = wdata_q;

    assign master0_busy     = req0 & ~((state_q == DONE) & ~grant_q);
    assign master1_busy     = req1 & ~((state_q == DONE) &  grant_q);
    assign master0_dataRead = rd0_q;
    assign master1_dataRead = rd1_q;
    assign busTimeout       = timeout_q;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Bench for peripheral_bus_arbiter (TIMEOUT_CYCLES=4): directed scenarios
// with literal expectations, then randomized traffic against a
// transaction-level model checked every cycle.
module tb_peripheral_bus_arbiter;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_we [2];
    logic        m_oe [2];
    logic [23:0] m_addr [2];
    logic [3:0]  m_bsel [2];
    logic [31:0] m_wd [2];
    logic [31:0] m0_rd, m1_rd;
    logic        m0_busy, m1_busy;
    logic        pb_we, pb_oe;
    logic [23:0] pb_addr;
    logic [3:0]  pb_bsel;
    logic [31:0] pb_wd;
    logic [31:0] s_data;
    logic        s_busy, s_reqout;
    logic        tmo_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    peripheral_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .master0_we(m_we[0]), .master0_oe(m_oe[0]), .master0_address(m_addr[0]),
        .master0_byteSelect(m_bsel[0]), .master0_dataWrite(m_wd[0]),
        .master0_dataRead(m0_rd), .master0_busy(m0_busy),
        .master1_we(m_we[1]), .master1_oe(m_oe[1]), .master1_address(m_addr[1]),
        .master1_byteSelect(m_bsel[1]), .master1_dataWrite(m_wd[1]),
        .master1_dataRead(m1_rd), .master1_busy(m1_busy),
        .peripheralBus_we(pb_we), .peripheralBus_oe(pb_oe),
        .peripheralBus_address(pb_addr), .peripheralBus_byteSelect(pb_bsel),
        .peripheralBus_dataWrite(pb_wd), .peripheralBus_dataRead(s_data),
        .peripheralBus_busy(s_busy), .peripheralBus_requestOutput(s_reqout),
        .busTimeout(tmo_o)
    );

    // ---------------- transaction-level model ----------------
    // phase: 0 waiting for a request, 1 transaction on the bus, 2 completed.
    int          phase;
    int          owner;      // master owning the current transaction
    int          last_served;
    int          waited;     // busy cycles already spent on the bus
    logic        t_we, t_oe;
    logic [23:0] t_addr;
    logic [3:0]  t_bsel;
    logic [31:0] t_wd;
    logic [31:0] rd [2];
    logic        tmo_pulse;

    function automatic logic wants(int n);
        return m_we[n] | m_oe[n];
    endfunction

    task automatic model_step();
        if (rst) begin
            phase = 0; owner = 0; last_served = 1; waited = 0;
            t_we = 0; t_oe = 0; t_addr = '0; t_bsel = '0; t_wd = '0;
            rd[0] = '1; rd[1] = '1; tmo_pulse = 0;
            return;
        end
        tmo_pulse = 0;
        if (phase == 0) begin
            if (wants(0) || wants(1)) begin
                if (wants(0) && wants(1)) owner = 1 - last_served;
                else                      owner = wants(1) ? 1 : 0;
                t_we = m_we[owner]; t_oe = m_oe[owner]; t_addr = m_addr[owner];
                t_bsel = m_bsel[owner]; t_wd = m_wd[owner];
                waited = 0;
                phase = 1;
            end
        end else if (phase == 1) begin
            if (!s_busy) begin
                if (t_oe) rd[owner] = s_reqout ? s_data : 32'hFFFF_FFFF;
                phase = 2;
            end else if (waited + 1 == TMO) begin
                rd[owner] = 32'hFFFF_FFFF;
                tmo_pulse = 1;
                phase = 2;
            end else begin
                waited++;
            end
        end else begin
            last_served = owner;
            phase = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model (called once per cycle).
    task automatic chk_all();
        #1;
        chk("pb_we",   32'(pb_we),   32'(phase == 1 && t_we));
        chk("pb_oe",   32'(pb_oe),   32'(phase == 1 && t_oe));
        chk("pb_addr", 32'(pb_addr), 32'(t_addr));
        chk("pb_bsel", 32'(pb_bsel), 32'(t_bsel));
        chk("pb_wd",   pb_wd,        t_wd);
        chk("m0_busy", 32'(m0_busy), 32'(wants(0) && !(phase == 2 && owner == 0)));
        chk("m1_busy", 32'(m1_busy), 32'(wants(1) && !(phase == 2 && owner == 1)));
        chk("m0_rd",   m0_rd,        rd[0]);
        chk("m1_rd",   m1_rd,        rd[1]);
        chk("timeout", 32'(tmo_o),   32'(tmo_pulse));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_masters();
        for (int n = 0; n < 2; n++) begin
            m_we[n] = 0; m_oe[n] = 0; m_addr[n] = '0; m_bsel[n] = '0; m_wd[n] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1; idle_masters();
        s_busy = 0; s_reqout = 0; s_data = '0;
        cycle();
        rst = 0;
    endtask

    task automatic new_req(input int n);
        logic [1:0] k;
        k = 2'($urandom_range(1, 3));
        m_we[n] = k[0]; m_oe[n] = k[1];
        m_addr[n] = 24'($urandom); m_bsel[n] = 4'($urandom); m_wd[n] = $urandom;
    endtask

    initial begin
        rst = 1; idle_masters();
        s_busy = 0; s_reqout = 0; s_data = '0;
        @(negedge clk);
        do_reset();

        // Reset state.
        chk_all();
        chk("rst_m0_rd", m0_rd, 32'hFFFF_FFFF);
        chk("rst_pb_addr", 32'(pb_addr), 32'h0);

        // Master 0 read, zero-wait slave.
        m_oe[0] = 1; m_addr[0] = 24'h030004; m_bsel[0] = 4'hF;
        s_busy = 0; s_reqout = 1; s_data = 32'h1234_5678;
        chk_all(); chk("rd_c0_oe", 32'(pb_oe), 32'd0);
        cycle(); chk_all();
        chk("rd_c1_oe", 32'(pb_oe), 32'd1);
        chk("rd_c1_addr", 32'(pb_addr), 32'h030004);
        cycle(); chk_all();
        chk("rd_c2_busy", 32'(m0_busy), 32'd0);
        chk("rd_c2_data", m0_rd, 32'h1234_5678);
        chk("rd_c2_m1", m1_rd, 32'hFFFF_FFFF);
        chk("rd_c2_oe", 32'(pb_oe), 32'd0);
        m_oe[0] = 0;
        cycle(); chk_all();

        // Master 1 write, slave busy for two cycles.
        m_we[1] = 1; m_addr[1] = 24'h031000; m_bsel[1] = 4'h3; m_wd[1] = 32'hA5A5_A5A5;
        chk_all(); cycle();
        for (int c = 1; c <= 3; c++) begin
            s_busy = (c < 3);
            chk_all();
            chk("wr_we", 32'(pb_we), 32'd1);
            chk("wr_wd", pb_wd, 32'hA5A5_A5A5);
            chk("wr_bsel", 32'(pb_bsel), 32'h3);
            chk("wr_addr", 32'(pb_addr), 32'h031000);
            cycle();
        end
        chk_all();
        chk("wr_c4_busy", 32'(m1_busy), 32'd0);
        chk("wr_c4_m1rd", m1_rd, 32'hFFFF_FFFF);
        m_we[1] = 0;
        cycle(); chk_all();

        // Read that nobody claims.
        m_oe[0] = 1; s_reqout = 0; s_data = 32'hDEAD_BEEF;
        chk_all(); cycle(); chk_all(); cycle(); chk_all();
        chk("unclaimed_rd", m0_rd, 32'hFFFF_FFFF);
        chk("unclaimed_tmo", 32'(tmo_o), 32'd0);
        m_oe[0] = 0; cycle(); chk_all();

        // Reload master 0 data, then time out a stuck slave.
        m_oe[0] = 1; s_reqout = 1; s_data = 32'h0BAD_F00D;
        chk_all(); cycle(); chk_all(); cycle(); chk_all();
        chk("reload_rd", m0_rd, 32'h0BAD_F00D);
        m_oe[0] = 0; cycle(); chk_all();
        m_oe[0] = 1; s_busy = 1;
        chk_all(); cycle();
        for (int c = 1; c <= 4; c++) begin
            chk_all();
            chk("tmo_access_oe", 32'(pb_oe), 32'd1);
            chk("tmo_access_pulse", 32'(tmo_o), 32'd0);
            cycle();
        end
        chk_all();
        chk("tmo_pulse", 32'(tmo_o), 32'd1);
        chk("tmo_rd", m0_rd, 32'hFFFF_FFFF);
        chk("tmo_busy", 32'(m0_busy), 32'd0);
        m_oe[0] = 0; s_busy = 0;
        cycle(); chk_all();
        chk("tmo_after", 32'(tmo_o), 32'd0);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        m_oe[0] = 1; m_addr[0] = 24'h00AAAA;
        m_oe[1] = 1; m_addr[1] = 24'h00BBBB;
        s_busy = 0; s_reqout = 1; s_data = 32'h5555_0000;
        for (int c = 0; c < 12; c++) begin
            chk_all();
            if (c % 3 == 1)
                chk("rr_addr", 32'(pb_addr), ((c / 3) % 2 == 1) ? 32'h00BBBB : 32'h00AAAA);
            if (c % 3 == 2)
                chk("rr_busy", 32'(((c / 3) % 2 == 1) ? m1_busy : m0_busy), 32'd0);
            cycle();
        end
        idle_masters(); cycle(); chk_all(); cycle(); chk_all();

        // Reset in the second ACCESS cycle of a stalled read.
        m_oe[1] = 1; m_addr[1] = 24'h001111; s_busy = 1;
        chk_all(); cycle(); chk_all(); cycle();
        rst = 1; cycle(); rst = 0;
        m_oe[0] = 1; m_addr[0] = 24'h002222;
        chk_all();
        chk("rstmid_oe", 32'(pb_oe), 32'd0);
        chk("rstmid_tmo", 32'(tmo_o), 32'd0);
        chk("rstmid_busy", 32'(m1_busy), 32'd1);
        chk("rstmid_addr", 32'(pb_addr), 32'd0);
        s_busy = 0;
        cycle(); chk_all();
        chk("rstmid_grant", 32'(pb_addr), 32'h002222);
        cycle(); chk_all();
        idle_masters(); cycle(); chk_all();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int n = 0; n < 2; n++) begin
                if (wants(n)) begin
                    if (phase == 2 && owner == n) begin
                        if ($urandom_range(0, 1) == 0) begin
                            m_we[n] = 0; m_oe[n] = 0;
                        end else new_req(n);
                    end else if ($urandom_range(0, 39) == 0) begin
                        m_we[n] = 0; m_oe[n] = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(n);
                end
            end
            s_busy = ($urandom_range(0, 99) < 45);
            s_reqout = ($urandom_range(0, 3) != 0);
            s_data = $urandom;
            chk_all();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
